// File: rtl/rx_gearbox.sv
// Receive gearbox: rebuilds 66-bit blocks from a 32-bit SerDes stream and emits
// each block as two 32-bit words, the first tagged with the 2-bit sync header.
module rx_gearbox #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_slip,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_valid,
    output logic [1:0]            o_hdr,
    output logic                  o_hdr_valid
);

    generate
        if (DATA_WIDTH != 32) begin : g_width_check
            $error("rx_gearbox: only DATA_WIDTH = 32 is supported");
        end
    endgenerate

    // A pending slip that stalls phase 0 at cnt = 2 leaves 34 bits behind, so
    // the working vector holds up to 66 bits rather than 64.
    localparam int ACC_W = 2 * DATA_WIDTH + 2;

    logic [ACC_W-1:0]      r_acc;
    logic [6:0]            r_cnt;
    logic                  r_phase;
    logic                  r_slip_pend;

    logic [ACC_W-1:0]      w_full;
    logic [ACC_W-1:0]      w_next_acc;
    logic [DATA_WIDTH+1:0] w_lo;
    logic [6:0]            w_avail;
    logic [6:0]            w_used;
    logic                  w_take_lo;
    logic                  w_take_hi;

    assign w_full    = r_acc | ({{(ACC_W-DATA_WIDTH){1'b0}}, i_data} << r_cnt);
    assign w_avail   = r_cnt + 7'd32;
    assign w_take_lo = !r_phase && (w_avail >= (7'd34 + {6'd0, r_slip_pend}));
    assign w_take_hi = r_phase && (w_avail >= 7'd32);
    assign w_lo      = r_slip_pend ? w_full[DATA_WIDTH+2:1] : w_full[DATA_WIDTH+1:0];

    always_comb begin
        w_used = 7'd0;
        if (w_take_lo) begin
            w_used = 7'd34 + {6'd0, r_slip_pend};
        end else if (w_take_hi) begin
            w_used = 7'd32;
        end
    end

    assign w_next_acc = w_full >> w_used;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_phase      <= 1'b0;
            r_slip_pend  <= 1'b0;
            o_data       <= '0;
            o_hdr        <= '0;
            o_data_valid <= 1'b0;
            o_hdr_valid  <= 1'b0;
        end else begin
            r_acc        <= w_next_acc;
            r_cnt        <= w_avail - w_used;
            o_data_valid <= w_take_lo | w_take_hi;
            o_hdr_valid  <= w_take_lo;
            // A slip arriving on a consuming cycle survives for the next block.
            r_slip_pend  <= (w_take_lo ? 1'b0 : r_slip_pend) | i_slip;
            if (w_take_lo) begin
                r_phase <= 1'b1;
                o_hdr   <= w_lo[1:0];
                o_data  <= w_lo[DATA_WIDTH+1:2];
            end else if (w_take_hi) begin
                r_phase <= 1'b0;
                o_data  <= w_full[DATA_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_rx_gearbox.sv
// Bench for rx_gearbox: random line stream, bit-queue reference model feeding a
// scoreboard, plus direct alignment checks against the serialized line bits.
module tb_rx_gearbox;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b1;
    logic [31:0] i_data = '0;
    logic        i_slip = 1'b0;
    logic [31:0] o_data;
    logic        o_data_valid;
    logic [1:0]  o_hdr;
    logic        o_hdr_valid;

    rx_gearbox #(.DATA_WIDTH(32)) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_data       (i_data),
        .i_slip       (i_slip),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .o_hdr        (o_hdr),
        .o_hdr_valid  (o_hdr_valid)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          cyc;
        bit          hv;
        logic [1:0]  hdr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    bit   src[$];
    bit   lbits[$];
    bit   mq[$];
    bit   pattern_mode = 1'b0;
    int   m_phase = 0;
    int   m_sp = 0;

    int          rel_cyc = 0;
    int          first_cyc = -1;
    bit          first_pending = 1'b0;
    int          hv_cnt = 0;
    logic [31:0] last_d = '0;
    logic [1:0]  last_h = '0;
    int          win_lo = 1, win_hi = 0, win_stalls = 0, win_words = 0, prev_stall = -1;
    bit          cnt_chk = 1'b0;
    int          cnt_max = 0;

    always @(posedge i_clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] lword(input int p);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = lbits[p + i];
        return r;
    endfunction

    // Serialise one 66-bit block onto the line, header first, LSB first.
    task automatic gen_block();
        logic [1:0]  h;
        logic [63:0] p;
        if (pattern_mode) begin
            h = 2'b01;
            p = {32'hDEADBEEF, 32'h01234567};
        end else begin
            h = 2'($urandom_range(0, 3));
            p = {$urandom, $urandom};
        end
        for (int i = 0; i < 2; i++) begin src.push_back(h[i]); lbits.push_back(h[i]); end
        for (int i = 0; i < 64; i++) begin src.push_back(p[i]); lbits.push_back(p[i]); end
    endtask

    task automatic model(input bit slip);
        exp_t e;
        if (m_phase == 0 && mq.size() >= 34 + m_sp) begin
            if (m_sp != 0) void'(mq.pop_front());
            e.hdr[0] = mq.pop_front();
            e.hdr[1] = mq.pop_front();
            for (int i = 0; i < 32; i++) e.data[i] = mq.pop_front();
            e.hv = 1'b1; e.cyc = cyc + 1;
            sb.push_back(e);
            m_phase = 1; m_sp = 0;
        end else if (m_phase == 1 && mq.size() >= 32) begin
            for (int i = 0; i < 32; i++) e.data[i] = mq.pop_front();
            e.hdr = 2'b00; e.hv = 1'b0; e.cyc = cyc + 1;
            sb.push_back(e);
            m_phase = 0;
        end
        if (slip) m_sp = 1;
    endtask

    task automatic step(input bit slip);
        logic [31:0] w;
        while (src.size() < 32) gen_block();
        for (int i = 0; i < 32; i++) begin
            w[i] = src.pop_front();
            mq.push_back(w[i]);
        end
        i_data = w;
        i_slip = slip;
        model(slip);
        @(posedge i_clk);
        #1;
    endtask

    // Asserts reset just after a monitor sample, restarts the line with j junk bits.
    task automatic do_reset(input int n, input int j, input bit pat);
        bit b;
        #6;
        i_reset_n = 1'b0;
        i_slip = 1'b0;
        sb.delete();
        pattern_mode = pat;
        src.delete(); lbits.delete(); mq.delete();
        m_phase = 0; m_sp = 0;
        for (int i = 0; i < j; i++) begin
            b = 1'($urandom);
            src.push_back(b); lbits.push_back(b);
        end
        repeat (n) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        first_cyc = -1;
        first_pending = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic seek_hdr(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (o_hdr_valid === 1'b1) begin ok = 1'b1; break; end
            step(1'b0);
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL hdr_timeout: no header word within 6 cycles (cycle %0d)", cyc);
        end
    endtask

    // The n-th header word starts at line bit 66*n + (slips applied so far).
    task automatic check_shift(input int off, input string name);
        bit ok;
        int p;
        seek_hdr(ok);
        if (ok) begin
            p = 66 * hv_cnt + off;
            chk({name, "_hdr"}, o_hdr, {lbits[p + 1], lbits[p]});
            chk({name, "_data"}, o_data, lword(p + 2));
        end
        step(1'b0);
    endtask

    always @(negedge i_clk) begin
        exp_t e;
        if (!i_reset_n) begin
            chk("reset_outputs", {o_data_valid, o_hdr_valid, o_hdr, o_data}, 64'd0);
            last_d = '0; last_h = '0; hv_cnt = 0;
        end else if (o_data_valid === 1'b1) begin
            if (cyc >= win_lo && cyc <= win_hi) win_words++;
            if (sb.size() == 0) begin
                chk("unexpected_word", o_data_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("word_cycle", cyc, e.cyc);
                chk("hdr_valid", o_hdr_valid, e.hv);
                chk("data", o_data, e.data);
                if (e.hv) chk("hdr", o_hdr, e.hdr);
            end
            if (pattern_mode) begin
                chk("pat_hv_tag", o_hdr_valid, o_data == 32'h01234567);
                chk("pat_word", (o_data == 32'h01234567) || (o_data == 32'hDEADBEEF), 1'b1);
                chk("pat_hdr", o_hdr, 2'b01);
            end
            if (o_hdr_valid === 1'b1) hv_cnt++;
            if (first_pending) begin first_cyc = cyc; first_pending = 1'b0; end
            last_d = o_data; last_h = o_hdr;
        end else begin
            chk("hold", {o_hdr, o_data, o_hdr_valid}, {last_h, last_d, 1'b0});
            if (cyc >= win_lo && cyc <= win_hi) begin
                win_stalls++;
                if (prev_stall >= 0) chk("stall_spacing", cyc - prev_stall, 33);
                prev_stall = cyc;
            end
            if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                chk("missing_word", o_data_valid, 1'b1);
                void'(sb.pop_front());
            end
        end
        if (cnt_chk && int'(dut.r_cnt) > cnt_max) cnt_max = int'(dut.r_cnt);
    end

    initial begin
        bit ok;
        int p;

        // Repeated fixed block, aligned.
        do_reset(3, 0, 1'b1);
        repeat (80) step(1'b0);
        chk("pat_first_valid", first_cyc, rel_cyc + 2);
        check_shift(0, "pat_align");

        // Aligned random blocks: stall cadence and fill bound.
        do_reset(3, 0, 1'b0);
        win_lo = rel_cyc + 1; win_hi = rel_cyc + 330;
        win_stalls = 0; win_words = 0; prev_stall = -1;
        cnt_chk = 1'b1; cnt_max = 0;
        repeat (331) step(1'b0);
        chk("window_stalls", win_stalls, 10);
        chk("window_words", win_words, 320);
        chk("cnt_max_le_32", cnt_max <= 32, 1'b1);
        cnt_chk = 1'b0; win_hi = 0;

        // Five junk bits removed by five slips.
        do_reset(3, 5, 1'b0);
        repeat (10) step(1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1);
            repeat (7) step(1'b0);
        end
        repeat (6) step(1'b0);
        check_shift(5, "junk_align");
        check_shift(5, "junk_align2");
        repeat (30) step(1'b0);

        // Slip raised while a header word is on the output.
        do_reset(3, 0, 1'b0);
        repeat (20) step(1'b0);
        seek_hdr(ok);
        if (ok) begin
            p = 66 * hv_cnt;
            chk("pre_slip_hdr", o_hdr, {lbits[p + 1], lbits[p]});
            step(1'b1);
            chk("slip_hi_flags", {o_data_valid, o_hdr_valid}, 2'b10);
            chk("slip_hi_data", o_data, lword(p + 34));
            check_shift(1, "slip_next");
        end
        repeat (20) step(1'b0);

        // Back-to-back slips discard a single bit.
        do_reset(3, 0, 1'b0);
        repeat (20) step(1'b0);
        seek_hdr(ok);
        step(1'b0);
        step(1'b1);
        step(1'b1);
        repeat (6) step(1'b0);
        check_shift(1, "dbl_slip");
        check_shift(1, "dbl_slip2");

        // Reset in the middle of a block, then a fresh aligned stream.
        repeat (7) step(1'b0);
        do_reset(3, 0, 1'b0);
        repeat (40) step(1'b0);
        chk("post_reset_first_valid", first_cyc, rel_cyc + 2);
        check_shift(0, "post_reset_align");
        repeat (10) step(1'b0);

        i_slip = 1'b0;
        @(negedge i_clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
